// File: rtl/access_control_pkg.sv
// Register map, bit positions and FSM encoding shared by the access-control sequencer.
package access_control_pkg;

   localparam int unsigned RegUpstr   = 0;
   localparam int unsigned RegUpendr  = 1;
   localparam int unsigned RegUpsrcar = 2;
   localparam int unsigned RegUpdstar = 3;

   localparam int unsigned UpstrStartBit = 0;
   localparam int unsigned UpendrDoneBit = 0;

   typedef enum logic [2:0] {
      StIdle,
      StClrStart,
      StRun,
      StWrEnd,
      StWaitAck
   } ac_state_e;

endpackage

// File: rtl/ac_pl_writer.sv
// Holds one register-file write request on the PL port until it is accepted (wrt & !busy).
module ac_pl_writer #(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned AddrWidth = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 load_i,
   input  logic [AddrWidth-1:0] addr_i,
   input  logic [DataWidth-1:0] data_i,
   input  logic                 wbusy_i,
   output logic                 wrt_o,
   output logic [AddrWidth-1:0] waddr_o,
   output logic [DataWidth-1:0] wdata_o,
   output logic                 accepted_o
);

   logic                 wrt_q, wrt_d;
   logic [AddrWidth-1:0] waddr_q, waddr_d;
   logic [DataWidth-1:0] wdata_q, wdata_d;

   assign accepted_o = wrt_q & ~wbusy_i;

   always_comb begin
      wrt_d   = wrt_q;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      if (accepted_o) begin
         wrt_d = 1'b0;
      end
      if (load_i) begin
         wrt_d   = 1'b1;
         waddr_d = addr_i;
         wdata_d = data_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wrt_q   <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         wrt_q   <= wrt_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   assign wrt_o   = wrt_q;
   assign waddr_o = waddr_q;
   assign wdata_o = wdata_q;

endmodule

// File: rtl/access_control.sv
// Sequencer: launches the up-sampling engine on a PS start request and reports completion
// with the elapsed cycle count through the register file's PL write port.
module access_control
   import access_control_pkg::*;
#(
   parameter int unsigned CRF_DATA_WIDTH = 32,
   parameter int unsigned CRF_ADDR_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CRF_DATA_WIDTH-1:0] crf_ac_UPSTR,
   input  logic [CRF_DATA_WIDTH-1:0] crf_ac_UPENDR,
   input  logic [CRF_DATA_WIDTH-1:0] crf_ac_UPSRCAR,
   input  logic [CRF_DATA_WIDTH-1:0] crf_ac_UPDSTAR,
   input  logic                      crf_ac_wbusy,
   output logic                      ac_crf_wrt,
   output logic [CRF_ADDR_WIDTH-1:0] ac_crf_waddr,
   output logic [CRF_DATA_WIDTH-1:0] ac_crf_wdata,
   output logic                      ac_up_start,
   output logic [CRF_DATA_WIDTH-1:0] ac_up_srcaddr,
   output logic [CRF_DATA_WIDTH-1:0] ac_up_dstaddr,
   input  logic                      up_ac_done,
   output logic                      ac_busy
);

   localparam logic [CRF_DATA_WIDTH-1:0] CountMax = {1'b0, {(CRF_DATA_WIDTH-1){1'b1}}};

   ac_state_e state_q, state_d;

   logic [CRF_DATA_WIDTH-1:0] count_q, count_d;
   logic [CRF_DATA_WIDTH-1:0] src_q, src_d;
   logic [CRF_DATA_WIDTH-1:0] dst_q, dst_d;
   logic                      pend_q, pend_d;
   logic                      start_q, start_d;

   logic                      start_req;
   logic                      finish;
   logic                      launch;
   logic                      wr_load;
   logic [CRF_ADDR_WIDTH-1:0] wr_addr;
   logic [CRF_DATA_WIDTH-1:0] wr_data;
   logic                      wr_accepted;

   logic unused_reg_bits;
   assign unused_reg_bits = ^{crf_ac_UPSTR[CRF_DATA_WIDTH-1:1],
                              crf_ac_UPENDR[CRF_DATA_WIDTH-1:1]};

   // A set done flag blocks relaunch until PS has consumed the previous result.
   assign start_req = crf_ac_UPSTR[UpstrStartBit] & ~crf_ac_UPENDR[UpendrDoneBit];
   assign finish    = up_ac_done | pend_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:     if (start_req)                          state_d = StClrStart;
         StClrStart: if (wr_accepted)                        state_d = StRun;
         StRun:      if (finish)                             state_d = StWrEnd;
         StWrEnd:    if (wr_accepted)                        state_d = StWaitAck;
         StWaitAck:  if (!crf_ac_UPENDR[UpendrDoneBit])      state_d = StIdle;
         default:                                            state_d = StIdle;
      endcase
   end

   always_comb begin
      launch  = 1'b0;
      wr_load = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      unique case (state_q)
         StIdle: begin
            if (start_req) begin
               launch  = 1'b1;
               wr_load = 1'b1;
               wr_addr = CRF_ADDR_WIDTH'(RegUpstr);
            end
         end
         StRun: begin
            if (finish) begin
               wr_load = 1'b1;
               wr_addr = CRF_ADDR_WIDTH'(RegUpendr);
               wr_data = {count_q[CRF_DATA_WIDTH-2:0], 1'b1};
            end
         end
         default: ;
      endcase
   end

   // Counting covers CLR_START too, so the count is measured from the start pulse.
   always_comb begin
      count_d = count_q;
      src_d   = src_q;
      dst_d   = dst_q;
      pend_d  = pend_q;
      start_d = launch;
      if (launch) begin
         count_d = '0;
         src_d   = crf_ac_UPSRCAR;
         dst_d   = crf_ac_UPDSTAR;
         pend_d  = 1'b0;
      end else if ((state_q == StClrStart) || ((state_q == StRun) && !finish)) begin
         if (count_q != CountMax) begin
            count_d = count_q + 1'b1;
         end
      end
      if ((state_q == StClrStart) && up_ac_done) begin
         pend_d = 1'b1;
      end
      if ((state_q == StRun) && finish) begin
         pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         src_q   <= '0;
         dst_q   <= '0;
         pend_q  <= 1'b0;
         start_q <= 1'b0;
      end else begin
         count_q <= count_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         pend_q  <= pend_d;
         start_q <= start_d;
      end
   end

   ac_pl_writer #(
      .DataWidth (CRF_DATA_WIDTH),
      .AddrWidth (CRF_ADDR_WIDTH)
   ) u_pl_writer (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_i     (wr_load),
      .addr_i     (wr_addr),
      .data_i     (wr_data),
      .wbusy_i    (crf_ac_wbusy),
      .wrt_o      (ac_crf_wrt),
      .waddr_o    (ac_crf_waddr),
      .wdata_o    (ac_crf_wdata),
      .accepted_o (wr_accepted)
   );

   assign ac_up_start   = start_q;
   assign ac_up_srcaddr = src_q;
   assign ac_up_dstaddr = dst_q;
   assign ac_busy       = (state_q != StIdle);

endmodule

// File: tb/tb_access_control.sv
// Bench for access_control: register-file and PS/engine environment, a job-level reference
// model checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_access_control;
   import access_control_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // 32-bit instance and its environment
   logic [31:0] rf [4] = '{default: 32'd0};
   logic        wbusy = 1'b0;
   logic        done  = 1'b0;
   logic        ps_we = 1'b0;
   logic [1:0]  ps_idx = 2'd0;
   logic [31:0] ps_data = 32'd0;

   logic        ac_crf_wrt, ac_up_start, ac_busy;
   logic [31:0] ac_crf_waddr, ac_crf_wdata, ac_up_srcaddr, ac_up_dstaddr;

   access_control #(
      .CRF_DATA_WIDTH (32),
      .CRF_ADDR_WIDTH (32)
   ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .crf_ac_UPSTR   (rf[RegUpstr]),
      .crf_ac_UPENDR  (rf[RegUpendr]),
      .crf_ac_UPSRCAR (rf[RegUpsrcar]),
      .crf_ac_UPDSTAR (rf[RegUpdstar]),
      .crf_ac_wbusy   (wbusy),
      .ac_crf_wrt     (ac_crf_wrt),
      .ac_crf_waddr   (ac_crf_waddr),
      .ac_crf_wdata   (ac_crf_wdata),
      .ac_up_start    (ac_up_start),
      .ac_up_srcaddr  (ac_up_srcaddr),
      .ac_up_dstaddr  (ac_up_dstaddr),
      .up_ac_done     (done),
      .ac_busy        (ac_busy)
   );

   // 8-bit instance for counter saturation
   logic [7:0]  s8_upstr = 8'd0;
   logic [7:0]  s8_upendr = 8'd0;
   logic [7:0]  s8_src = 8'h5A;
   logic [7:0]  s8_dst = 8'hA5;
   logic        s8_wbusy = 1'b0;
   logic        done8 = 1'b0;
   logic        wrt8, start8, busy8;
   logic [31:0] waddr8;
   logic [7:0]  wdata8, src8, dst8;

   access_control #(
      .CRF_DATA_WIDTH (8),
      .CRF_ADDR_WIDTH (32)
   ) u_dut8 (
      .clk            (clk),
      .rst            (rst),
      .crf_ac_UPSTR   (s8_upstr),
      .crf_ac_UPENDR  (s8_upendr),
      .crf_ac_UPSRCAR (s8_src),
      .crf_ac_UPDSTAR (s8_dst),
      .crf_ac_wbusy   (s8_wbusy),
      .ac_crf_wrt     (wrt8),
      .ac_crf_waddr   (waddr8),
      .ac_crf_wdata   (wdata8),
      .ac_up_start    (start8),
      .ac_up_srcaddr  (src8),
      .ac_up_dstaddr  (dst8),
      .up_ac_done     (done8),
      .ac_busy        (busy8)
   );

   // Register file: accepted PL writes, then PS writes (PS wins on a same-cycle collision)
   int n_wr0 = 0, n_wr1 = 0, n_start = 0;
   always @(posedge clk) begin
      if (ac_crf_wrt && !wbusy) begin
         if (ac_crf_waddr == 32'd0) begin
            rf[0] <= ac_crf_wdata;
            n_wr0 <= n_wr0 + 1;
         end else if (ac_crf_waddr == 32'd1) begin
            rf[1] <= ac_crf_wdata;
            n_wr1 <= n_wr1 + 1;
         end
      end
      if (ps_we) rf[ps_idx] <= ps_data;
      if (ac_up_start) n_start <= n_start + 1;
   end

   // Reference model: tracks the job phase and derives the count as now - start_cycle.
   localparam int PhIdle = 0, PhClear = 1, PhRun = 2, PhReport = 3, PhAck = 4;
   localparam int CntMax32 = 2147483647;
   int          m_ph = PhIdle, m_now = 0, m_t0 = 0;
   bit          m_pend = 1'b0;
   logic        m_wrt = 1'b0, m_start = 1'b0, m_busy = 1'b0;
   logic [31:0] m_waddr = '0, m_wdata = '0, m_src = '0, m_dst = '0;

   always @(posedge clk or posedge rst) begin
      bit acc;
      int el;
      if (rst) begin
         m_ph = PhIdle; m_now = 0; m_t0 = 0; m_pend = 1'b0;
         m_wrt = 1'b0; m_start = 1'b0; m_busy = 1'b0;
         m_waddr = '0; m_wdata = '0; m_src = '0; m_dst = '0;
      end else begin
         acc = m_wrt && !wbusy;
         if (acc) m_wrt = 1'b0;
         m_start = 1'b0;
         case (m_ph)
            PhIdle: if (rf[0][0] && !rf[1][0]) begin
               m_src = rf[2]; m_dst = rf[3]; m_start = 1'b1;
               m_wrt = 1'b1; m_waddr = 32'd0; m_wdata = 32'd0;
               m_t0 = m_now + 1; m_pend = 1'b0; m_ph = PhClear;
            end
            PhClear: begin
               if (done) m_pend = 1'b1;
               if (acc) m_ph = PhRun;
            end
            PhRun: if (done || m_pend) begin
               el = m_now - m_t0;
               if (el > CntMax32) el = CntMax32;
               m_wrt = 1'b1; m_waddr = 32'd1; m_wdata = 32'(2 * el + 1);
               m_pend = 1'b0; m_ph = PhReport;
            end
            PhReport: if (acc) m_ph = PhAck;
            PhAck: if (!rf[1][0]) m_ph = PhIdle;
            default: m_ph = PhIdle;
         endcase
         m_busy = (m_ph != PhIdle);
         m_now = m_now + 1;
      end
   end

   int n_cmp = 0, n_fail = 0;
   bit sim_done = 1'b0;

   task automatic chk(input string name, input logic [130:0] act, input logic [130:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h required %h", name, $time, act, exp);
      end
   endtask

   task automatic ps_write(input logic [1:0] idx, input logic [31:0] data);
      ps_we = 1'b1; ps_idx = idx; ps_data = data;
      @(negedge clk);
      ps_we = 1'b0;
   endtask

   task automatic pulse_done();
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
   endtask

   task automatic wait_start(input string name);
      int k = 0;
      while (!ac_up_start && k < 10) begin
         @(negedge clk);
         k++;
      end
      chk(name, ac_up_start, 1);
   endtask

   task automatic wait_wr(input logic [31:0] addr, input string name);
      int k = 0;
      while (!(ac_crf_wrt && ac_crf_waddr == addr) && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk(name, {ac_crf_wrt, ac_crf_waddr}, {1'b1, addr});
   endtask

   task automatic job8(input int lat, input logic [7:0] exp, input string name);
      int k = 0;
      s8_upstr = 8'd1;
      while (!start8 && k < 10) begin
         @(negedge clk);
         k++;
      end
      chk({name, "_start"}, start8, 1);
      s8_upstr = 8'd0;
      repeat (lat) @(negedge clk);
      done8 = 1'b1;
      @(negedge clk);
      done8 = 1'b0;
      k = 0;
      while (!(wrt8 && waddr8 == 32'd1) && k < 10) begin
         @(negedge clk);
         k++;
      end
      chk(name, {wrt8, wdata8}, {1'b1, exp});
      repeat (3) @(negedge clk);
   endtask

   initial begin
      fork
         begin : compare
            while (!sim_done) begin
               @(posedge clk);
               #3;
               chk("cycle",
                   {ac_crf_wrt, ac_crf_waddr, ac_crf_wdata, ac_up_start,
                    ac_up_srcaddr, ac_up_dstaddr, ac_busy},
                   {m_wrt, m_waddr, m_wdata, m_start, m_src, m_dst, m_busy});
            end
         end
         begin : stimulus
            int s0, w0, w1, r;
            repeat (3) @(negedge clk);
            chk("reset_outputs",
                {ac_crf_wrt, ac_crf_waddr, ac_crf_wdata, ac_up_start,
                 ac_up_srcaddr, ac_up_dstaddr, ac_busy}, '0);
            rst = 1'b0;
            @(negedge clk);

            // Basic job: done 100 cycles after the start pulse
            s0 = n_start; w0 = n_wr0; w1 = n_wr1;
            ps_write(2'd2, 32'h1000_0000);
            ps_write(2'd3, 32'h2000_0000);
            ps_write(2'd0, 32'd1);
            wait_start("basic_start");
            chk("basic_src", ac_up_srcaddr, 32'h1000_0000);
            chk("basic_dst", ac_up_dstaddr, 32'h2000_0000);
            repeat (100) @(negedge clk);
            pulse_done();
            wait_wr(32'd1, "basic_endr_wrt");
            chk("basic_endr_data", ac_crf_wdata, 32'h0000_00C9);
            repeat (10) @(negedge clk);
            chk("basic_parked", ac_busy, 1);
            chk("basic_one_start", n_start - s0, 1);
            chk("basic_writes", {n_wr0 - w0, n_wr1 - w1}, {32'd1, 32'd1});
            ps_write(2'd1, 32'd0);
            @(negedge clk);
            chk("basic_idle", ac_busy, 0);

            // Write stalls in both write states
            w0 = n_wr0; w1 = n_wr1;
            wbusy = 1'b1;
            ps_write(2'd0, 32'd1);
            wait_wr(32'd0, "stall_clr_wrt");
            repeat (5) @(negedge clk);
            chk("stall_clr_hold", {ac_crf_wrt, ac_crf_waddr, ac_crf_wdata}, {1'b1, 64'd0});
            wbusy = 1'b0;
            repeat (20) @(negedge clk);
            wbusy = 1'b1;
            pulse_done();
            wait_wr(32'd1, "stall_end_wrt");
            repeat (7) @(negedge clk);
            chk("stall_end_hold", {ac_crf_wrt, ac_crf_waddr}, {1'b1, 32'd1});
            wbusy = 1'b0;
            @(negedge clk);
            chk("stall_writes", {n_wr0 - w0, n_wr1 - w1}, {32'd1, 32'd1});
            repeat (2) @(negedge clk);
            ps_write(2'd1, 32'd0);
            repeat (2) @(negedge clk);

            // Early done while the UPSTR clear is stalled
            wbusy = 1'b1;
            ps_write(2'd0, 32'd1);
            wait_wr(32'd0, "early_clr_wrt");
            pulse_done();
            repeat (3) @(negedge clk);
            wbusy = 1'b0;
            @(negedge clk);
            chk("early_gap", ac_crf_wrt, 0);
            @(negedge clk);
            chk("early_endr", {ac_crf_wrt, ac_crf_waddr}, {1'b1, 32'd1});
            repeat (3) @(negedge clk);
            ps_write(2'd1, 32'd0);
            repeat (2) @(negedge clk);

            // No retrigger while the done flag is still set
            ps_write(2'd1, 32'd1);
            ps_write(2'd0, 32'd1);
            s0 = n_start;
            repeat (50) @(negedge clk);
            chk("noretrig_none", {n_start - s0, 31'd0, ac_busy}, '0);
            ps_write(2'd1, 32'd0);
            chk("noretrig_not_yet", ac_up_start, 0);
            @(negedge clk);
            chk("noretrig_start", ac_up_start, 1);
            repeat (15) @(negedge clk);
            pulse_done();
            wait_wr(32'd1, "noretrig_endr");
            repeat (3) @(negedge clk);
            ps_write(2'd1, 32'd0);
            repeat (2) @(negedge clk);

            // Reset in RUN, then a fresh job
            ps_write(2'd0, 32'd1);
            wait_start("rst_job_start");
            repeat (10) @(negedge clk);
            rst = 1'b1;
            #1;
            chk("rst_async",
                {ac_crf_wrt, ac_crf_waddr, ac_crf_wdata, ac_up_start,
                 ac_up_srcaddr, ac_up_dstaddr, ac_busy}, '0);
            @(negedge clk);
            rst = 1'b0;
            repeat (2) @(negedge clk);
            ps_write(2'd0, 32'd1);
            wait_start("fresh_start");
            repeat (30) @(negedge clk);
            pulse_done();
            wait_wr(32'd1, "fresh_endr_wrt");
            chk("fresh_endr_data", ac_crf_wdata, 32'h0000_003D);
            repeat (3) @(negedge clk);
            ps_write(2'd1, 32'd0);
            repeat (2) @(negedge clk);

            // Counter saturation on the 8-bit instance
            job8(300, 8'hFF, "sat_300");
            job8(50, 8'h65, "count_50");

            // Random traffic
            for (int i = 0; i < 3000; i++) begin
               wbusy = ($urandom_range(99) < 30);
               done  = ($urandom_range(99) < 4);
               ps_we = 1'b0;
               r = int'($urandom_range(99));
               if (rf[1][0] && r < 15) begin
                  ps_we = 1'b1; ps_idx = 2'd1; ps_data = 32'd0;
               end else if (!rf[0][0] && r < 25) begin
                  ps_we = 1'b1; ps_idx = 2'd0; ps_data = 32'd1;
               end else if (r < 35) begin
                  ps_we = 1'b1; ps_idx = (r < 30) ? 2'd2 : 2'd3; ps_data = $urandom;
               end
               @(negedge clk);
            end
            ps_we = 1'b0; wbusy = 1'b0; done = 1'b0;
            repeat (5) @(negedge clk);
            sim_done = 1'b1;
         end
      join
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
